fetch_stage: RTL and testbench

//   IF stage plus IF/ID pipeline register. Holds the PC and issues word fetches to

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID register with one-outstanding imem fetch.
// Define FETCH_MISALIGN_EN to add the sticky fetch_misaligned flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] redirect_target;
  logic        hold_valid;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        halted;
  logic        accept;
  logic        capture;

`ifdef FETCH_MISALIGN_EN
  logic misaligned_q;

  assign redirect_target  = redirect_pc;
  assign halted           = misaligned_q;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign halted          = 1'b0;
`endif

  // A new request may ride on the response edge so a 1-cycle memory streams back to back.
  assign imem_req_valid = rst_n & ~redirect_valid & ~hold_valid & ~halted &
                          ((state == IDLE) |
                           ((state == WAIT) & imem_rsp_valid & ~stall));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign capture        = (state == WAIT) & imem_rsp_valid & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      // A request still in flight becomes stale and its response must be swallowed.
      if (state == WAIT) begin
        state_nxt = imem_rsp_valid ? IDLE : DROP;
      end
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = WAIT;
        WAIT: if (imem_rsp_valid) state_nxt = accept ? WAIT : IDLE;
        DROP: if (imem_rsp_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      req_pc      <= 32'h0;
      hold_valid  <= 1'b0;
      hold_instr  <= 32'h0;
      hold_pc     <= 32'h0;
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (accept) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end

      // Stalled responses park in the hold buffer; fetching pauses until it drains.
      if (redirect_valid) begin
        hold_valid <= 1'b0;
      end else if (capture && stall) begin
        hold_valid <= 1'b1;
        hold_instr <= imem_rsp_data;
        hold_pc    <= req_pc;
      end else if (hold_valid && !stall) begin
        hold_valid <= 1'b0;
      end

      if (redirect_valid) begin
        id_valid <= 1'b0;
      end else if (!stall) begin
        if (hold_valid) begin
          id_valid    <= 1'b1;
          id_instr    <= hold_instr;
          id_pc       <= hold_pc;
          id_pc_plus4 <= hold_pc + 32'd4;
        end else if (capture) begin
          id_valid    <= 1'b1;
          id_instr    <= imem_rsp_data;
          id_pc       <= req_pc;
          id_pc_plus4 <= req_pc + 32'd4;
        end else begin
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a variable-latency imem model.
// Honours FETCH_MISALIGN_EN for the misaligned-redirect scenario.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_del = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  logic        stopped = 1'b0;
  logic        have_pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  int          mem_lat = 1;
  logic        last_req = 1'b0;
  logic [31:0] last_addr = 32'h0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (have_pend && pend_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = tag(pend_addr);
      have_pend      = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (have_pend) pend_cnt--;
    end
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if (rv && rst_n) begin
`ifdef FETCH_MISALIGN_EN
      if (rpc[1:0] != 2'b00) stopped = 1'b1;
      exp_pc = rpc;
`else
      exp_pc = rpc & 32'hFFFF_FFFC;
`endif
    end
    #1;
    last_req  = imem_req_valid;
    last_addr = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      n_cmp++;
      if (imem_req_addr !== exp_pc || have_pend || stopped) begin
        n_err++;
        $display("FAIL req_addr: got %h want %h (outstanding=%0b stopped=%0b)",
                 imem_req_addr, exp_pc, have_pend, stopped);
      end
      exp_q.push_back(exp_pc);
      have_pend = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = mem_lat - 1;
      exp_pc    = exp_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  logic         mon_st, mon_rv, mon_rn;
  logic [31:0]  mon_e;
  logic [96:0]  snap = '0;

  always @(posedge clk) begin
    mon_st = stall;
    mon_rv = redirect_valid;
    mon_rn = rst_n;
    #1;
    if (mon_rn) begin
      if (mon_rv) begin
        exp_q.delete();
        n_cmp++;
        if (id_valid !== 1'b0) begin
          n_err++;
          $display("FAIL sb_redirect_kill: id_valid got %b want 0", id_valid);
        end
      end else if (mon_st) begin
        n_cmp++;
        if ({id_valid, id_instr, id_pc, id_pc_plus4} !== snap) begin
          n_err++;
          $display("FAIL sb_stall_hold: id got %h want %h", {id_valid, id_instr, id_pc, id_pc_plus4}, snap);
        end
      end else if (id_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: id_pc got %h want no instruction", id_pc);
        end else begin
          mon_e = exp_q.pop_front();
          n_del++;
          if (id_pc !== mon_e || id_instr !== tag(mon_e) || id_pc_plus4 !== mon_e + 32'd4) begin
            n_err++;
            $display("FAIL sb_id: got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                     id_pc, id_instr, id_pc_plus4, mon_e, tag(mon_e), mon_e + 32'd4);
          end
        end
      end
    end
    snap = {id_valid, id_instr, id_pc, id_pc_plus4};
  end

  task automatic do_reset;
    rst_n     = 1'b0;
    have_pend = 1'b0;
    stopped   = 1'b0;
    mem_lat   = 1;
    exp_q.delete();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req: imem_req_valid got %b want 0", last_req);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    exp_pc = 32'h0;
    rst_n  = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({id_valid, id_instr, id_pc, id_pc_plus4} !== 97'h0) begin
      n_err++;
      $display("FAIL reset_id: got %h want 0", {id_valid, id_instr, id_pc, id_pc_plus4});
    end
`ifdef FETCH_MISALIGN_EN
    n_cmp++;
    if (fetch_misaligned !== 1'b0) begin
      n_err++;
      $display("FAIL reset_misaligned: got %b want 0", fetch_misaligned);
    end
`endif
  endtask

  task automatic test_stream;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (k == 1) begin
        if (last_req !== 1'b1 || last_addr !== 32'h0 || id_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_first: req=%b addr=%h id_valid=%b want 1 00000000 0", last_req, last_addr, id_valid);
        end
      end else if (id_valid !== 1'b1 || id_pc !== 32'(4 * (k - 2))) begin
        n_err++;
        $display("FAIL stream_pc: valid=%b pc=%h want 1 %h", id_valid, id_pc, 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] frozen;
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    frozen = id_pc;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (last_req !== 1'b0 || id_pc !== frozen || id_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_freeze: req=%b pc=%h valid=%b want 0 %h 1", last_req, id_pc, id_valid, frozen);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_req !== 1'b0 || id_pc !== frozen + 32'd4) begin
      n_err++;
      $display("FAIL stall_drain: req=%b pc=%h want 0 %h", last_req, id_pc, frozen + 32'd4);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== frozen + 32'd8 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_resume: req=%b addr=%h valid=%b want 1 %h 0", last_req, last_addr, id_valid, frozen + 32'd8);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== frozen + 32'd8) begin
      n_err++;
      $display("FAIL stall_next: valid=%b pc=%h want 1 %h", id_valid, id_pc, frozen + 32'd8);
    end
  endtask

  task automatic test_redirect_wait;
    logic        found;
    logic [31:0] first_pc;
    found    = 1'b0;
    first_pc = 32'h0;
    do_reset();
    mem_lat = 2;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    n_cmp++;
    if (last_req !== 1'b0) begin
      n_err++;
      $display("FAIL redir_wait_req: got %b want 0", last_req);
    end
    for (int k = 0; k < 12 && !found; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (id_valid === 1'b1) begin
        found    = 1'b1;
        first_pc = id_pc;
      end
    end
    n_cmp++;
    if (!found || first_pc !== 32'h100) begin
      n_err++;
      $display("FAIL redir_wait_target: found=%b pc=%h want 1 00000100", found, first_pc);
    end
  endtask

  task automatic test_redirect_rsp_stall;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h200, 1'b1);
    n_cmp++;
    if (last_req !== 1'b0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_rsp_kill: req=%b valid=%b want 0 0", last_req, id_valid);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h200) begin
      n_err++;
      $display("FAIL redir_rsp_next: req=%b addr=%h want 1 00000200", last_req, last_addr);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      n_err++;
      $display("FAIL redir_rsp_id: valid=%b pc=%h want 1 00000200", id_valid, id_pc);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", last_req, last_addr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_id: addr=%h pc=%h pc4=%h want 00000000 fffffffc 00000000", last_addr, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_misalign;
    do_reset();
    cycle(1'b0, 1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_EN
    n_cmp++;
    if (fetch_misaligned !== 1'b1) begin
      n_err++;
      $display("FAIL misalign_flag: got %b want 1", fetch_misaligned);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (last_req !== 1'b0 || fetch_misaligned !== 1'b1) begin
        n_err++;
        $display("FAIL misalign_halt: req=%b flag=%b want 0 1", last_req, fetch_misaligned);
      end
    end
`else
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h100) begin
      n_err++;
      $display("FAIL misalign_mask: req=%b addr=%h want 1 00000100", last_req, last_addr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      n_err++;
      $display("FAIL misalign_id: valid=%b pc=%h want 1 00000100", id_valid, id_pc);
    end
`endif
  endtask

  task automatic test_back_to_back;
    int del0;
    do_reset();
    del0 = n_del;
    for (int k = 0; k < 400; k++) begin
      mem_lat = $urandom_range(1, 3);
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
            ($urandom() & 32'hFFFF_FFFC), ($urandom_range(0, 3) != 0));
    end
    n_cmp++;
    if (n_del - del0 < 50) begin
      n_err++;
      $display("FAIL b2b_progress: delivered %0d want at least 50", n_del - del0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp_stall();
    test_wrap();
    test_misalign();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
